// File: rtl/reservation_station_pkg.sv
// Shared constants for the reservation station: tag/op encodings and bus widths.
//   ROB_RESET     : tag value the ROB never allocates; means "operand value valid".
//   OP_ENUM_*     : operation encodings; OP_ENUM_RESET is the idle/reset op.
//   rob_t, op_enum_t, data_t, addr_t : default-width bus types.
package reservation_station_pkg;

  localparam int unsigned ROB_W_DEF = 5;
  localparam int unsigned OP_W_DEF  = 6;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;

  typedef logic [ROB_W_DEF-1:0] rob_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ADDR_W-1:0]    addr_t;

  localparam rob_t ROB_RESET = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ENUM_RESET = 6'd0,
    OP_ENUM_LUI   = 6'd1,
    OP_ENUM_AUIPC = 6'd2,
    OP_ENUM_JAL   = 6'd3,
    OP_ENUM_JALR  = 6'd4,
    OP_ENUM_BEQ   = 6'd5,
    OP_ENUM_BNE   = 6'd6,
    OP_ENUM_ADD   = 6'd7,
    OP_ENUM_SUB   = 6'd8,
    OP_ENUM_AND   = 6'd9,
    OP_ENUM_OR    = 6'd10,
    OP_ENUM_XOR   = 6'd11,
    OP_ENUM_ADDI  = 6'd12
  } op_enum_t;

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-index-set-bit encoder.
//   req     : request vector
//   found_c : any bit of req set
//   idx_c   : index of the lowest set bit (0 when none)
module rs_priority_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan high to low so the lowest set bit is written last and wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer for ALU/branch/jump instructions.
//   clk_in, rst_in (async, active-low), rdy_in (low freezes state)
//   *_from_dispatcher : one insert per cycle; is_full_to_dispatcher stalls it
//   *_from_alu / *_from_lsu : result broadcasts used to wake waiting operands
//   rollback_flag_from_rob : flush all entries
//   *_to_alu : registered issue port, one ready instruction per cycle
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 5,
  parameter int unsigned OP_W    = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              enable_from_dispatcher,
  input  logic [OP_W-1:0]   op_enum_from_dispatcher,
  input  logic [DATA_W-1:0] V1_from_dispatcher,
  input  logic [DATA_W-1:0] V2_from_dispatcher,
  input  logic [ROB_W-1:0]  Q1_from_dispatcher,
  input  logic [ROB_W-1:0]  Q2_from_dispatcher,
  input  logic [DATA_W-1:0] imm_from_dispatcher,
  input  logic [ADDR_W-1:0] inst_pos_from_dispatcher,
  input  logic [ROB_W-1:0]  rob_id_from_dispatcher,
  output logic              is_full_to_dispatcher,
  input  logic              enable_from_alu,
  input  logic [ROB_W-1:0]  rob_id_from_alu,
  input  logic [DATA_W-1:0] result_from_alu,
  input  logic              enable_from_lsu,
  input  logic [ROB_W-1:0]  rob_id_from_lsu,
  input  logic [DATA_W-1:0] result_from_lsu,
  input  logic              rollback_flag_from_rob,
  output logic              enable_to_alu,
  output logic [OP_W-1:0]   op_enum_to_alu,
  output logic [DATA_W-1:0] V1_to_alu,
  output logic [DATA_W-1:0] V2_to_alu,
  output logic [DATA_W-1:0] imm_to_alu,
  output logic [ADDR_W-1:0] inst_pos_to_alu,
  output logic [ROB_W-1:0]  rob_id_to_alu
);

  localparam int unsigned      IDX_W = $clog2(RS_SIZE);
  localparam int unsigned      CNT_W = IDX_W + 1;
  localparam logic [ROB_W-1:0] RR    = ROB_W'(ROB_RESET);

  logic [RS_SIZE-1:0] busy;
  logic [CNT_W-1:0]   count;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [DATA_W-1:0]  v1_q  [RS_SIZE];
  logic [DATA_W-1:0]  v2_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [ADDR_W-1:0]  pc_q  [RS_SIZE];
  logic [ROB_W-1:0]   q1_q  [RS_SIZE];
  logic [ROB_W-1:0]   q2_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];

  logic [RS_SIZE-1:0] ready, w1_alu, w1_lsu, w2_alu, w2_lsu;
  logic               free_found, ready_found, do_insert;
  logic [IDX_W-1:0]   free_idx, ready_idx;
  logic [ROB_W-1:0]   ins_q1, ins_q2;
  logic [DATA_W-1:0]  ins_v1, ins_v2;

  // Full when at most the single slack entry for the in-flight insert remains.
  assign is_full_to_dispatcher = (CNT_W'(RS_SIZE) - count) <= CNT_W'(1);

  // Per-entry wake-up matches and readiness from registered state.
  for (genvar i = 0; i < int'(RS_SIZE); i++) begin : g_wake
    assign w1_alu[i] = enable_from_alu && (q1_q[i] == rob_id_from_alu) && (q1_q[i] != RR);
    assign w1_lsu[i] = enable_from_lsu && (q1_q[i] == rob_id_from_lsu) && (q1_q[i] != RR);
    assign w2_alu[i] = enable_from_alu && (q2_q[i] == rob_id_from_alu) && (q2_q[i] != RR);
    assign w2_lsu[i] = enable_from_lsu && (q2_q[i] == rob_id_from_lsu) && (q2_q[i] != RR);
    assign ready[i]  = busy[i] && (q1_q[i] == RR) && (q2_q[i] == RR);
  end

  rs_priority_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req     (~busy),
    .found_c (free_found),
    .idx_c   (free_idx)
  );

  rs_priority_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req     (ready),
    .found_c (ready_found),
    .idx_c   (ready_idx)
  );

  assign do_insert = enable_from_dispatcher && free_found;

  // Same-cycle snoop of incoming operands; ALU broadcast beats LSU.
  always_comb begin
    ins_q1 = Q1_from_dispatcher;
    ins_v1 = V1_from_dispatcher;
    ins_q2 = Q2_from_dispatcher;
    ins_v2 = V2_from_dispatcher;
    if (Q1_from_dispatcher != RR) begin
      if (enable_from_alu && (Q1_from_dispatcher == rob_id_from_alu)) begin
        ins_q1 = RR;
        ins_v1 = result_from_alu;
      end else if (enable_from_lsu && (Q1_from_dispatcher == rob_id_from_lsu)) begin
        ins_q1 = RR;
        ins_v1 = result_from_lsu;
      end
    end
    if (Q2_from_dispatcher != RR) begin
      if (enable_from_alu && (Q2_from_dispatcher == rob_id_from_alu)) begin
        ins_q2 = RR;
        ins_v2 = result_from_alu;
      end else if (enable_from_lsu && (Q2_from_dispatcher == rob_id_from_lsu)) begin
        ins_q2 = RR;
        ins_v2 = result_from_lsu;
      end
    end
  end

  // Entry storage, issue register and occupancy count.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy            <= '0;
      count           <= '0;
      enable_to_alu   <= 1'b0;
      op_enum_to_alu  <= OP_W'(OP_ENUM_RESET);
      V1_to_alu       <= '0;
      V2_to_alu       <= '0;
      imm_to_alu      <= '0;
      inst_pos_to_alu <= '0;
      rob_id_to_alu   <= RR;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        q1_q[i]  <= RR;
        q2_q[i]  <= RR;
        rob_q[i] <= RR;
      end
    end else if (rollback_flag_from_rob) begin
      busy          <= '0;
      count         <= '0;
      enable_to_alu <= 1'b0;
    end else if (!rdy_in) begin
      // Drop the valid so a held issue register is not executed twice.
      enable_to_alu <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (busy[i]) begin
          if (w1_alu[i]) begin
            q1_q[i] <= RR;
            v1_q[i] <= result_from_alu;
          end else if (w1_lsu[i]) begin
            q1_q[i] <= RR;
            v1_q[i] <= result_from_lsu;
          end
          if (w2_alu[i]) begin
            q2_q[i] <= RR;
            v2_q[i] <= result_from_alu;
          end else if (w2_lsu[i]) begin
            q2_q[i] <= RR;
            v2_q[i] <= result_from_lsu;
          end
        end
      end
      if (do_insert) begin
        op_q[free_idx]  <= op_enum_from_dispatcher;
        v1_q[free_idx]  <= ins_v1;
        v2_q[free_idx]  <= ins_v2;
        q1_q[free_idx]  <= ins_q1;
        q2_q[free_idx]  <= ins_q2;
        imm_q[free_idx] <= imm_from_dispatcher;
        pc_q[free_idx]  <= inst_pos_from_dispatcher;
        rob_q[free_idx] <= rob_id_from_dispatcher;
      end
      enable_to_alu <= ready_found;
      if (ready_found) begin
        op_enum_to_alu  <= op_q[ready_idx];
        V1_to_alu       <= v1_q[ready_idx];
        V2_to_alu       <= v2_q[ready_idx];
        imm_to_alu      <= imm_q[ready_idx];
        inst_pos_to_alu <= pc_q[ready_idx];
        rob_id_to_alu   <= rob_q[ready_idx];
      end
      // Free slot is chosen from pre-issue busy, so a just-issued slot is not reused this edge.
      busy  <= (busy & ~(RS_SIZE'(ready_found) << ready_idx))
             | (RS_SIZE'(do_insert) << free_idx);
      count <= count + CNT_W'(do_insert) - CNT_W'(ready_found);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Randomised and directed bench for reservation_station against an array-based model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int unsigned      RS_SIZE = 16;
  localparam int unsigned      ROB_W   = 5;
  localparam int unsigned      OP_W    = 6;
  localparam logic [ROB_W-1:0] RR      = ROB_W'(ROB_RESET);

  logic              clk_in, rst_in, rdy_in;
  logic              enable_from_dispatcher;
  logic [OP_W-1:0]   op_enum_from_dispatcher;
  logic [31:0]       V1_from_dispatcher, V2_from_dispatcher;
  logic [ROB_W-1:0]  Q1_from_dispatcher, Q2_from_dispatcher;
  logic [31:0]       imm_from_dispatcher, inst_pos_from_dispatcher;
  logic [ROB_W-1:0]  rob_id_from_dispatcher;
  logic              is_full_to_dispatcher;
  logic              enable_from_alu, enable_from_lsu;
  logic [ROB_W-1:0]  rob_id_from_alu, rob_id_from_lsu;
  logic [31:0]       result_from_alu, result_from_lsu;
  logic              rollback_flag_from_rob;
  logic              enable_to_alu;
  logic [OP_W-1:0]   op_enum_to_alu;
  logic [31:0]       V1_to_alu, V2_to_alu, imm_to_alu, inst_pos_to_alu;
  logic [ROB_W-1:0]  rob_id_to_alu;

  reservation_station #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .rdy_in                   (rdy_in),
    .enable_from_dispatcher   (enable_from_dispatcher),
    .op_enum_from_dispatcher  (op_enum_from_dispatcher),
    .V1_from_dispatcher       (V1_from_dispatcher),
    .V2_from_dispatcher       (V2_from_dispatcher),
    .Q1_from_dispatcher       (Q1_from_dispatcher),
    .Q2_from_dispatcher       (Q2_from_dispatcher),
    .imm_from_dispatcher      (imm_from_dispatcher),
    .inst_pos_from_dispatcher (inst_pos_from_dispatcher),
    .rob_id_from_dispatcher   (rob_id_from_dispatcher),
    .is_full_to_dispatcher    (is_full_to_dispatcher),
    .enable_from_alu          (enable_from_alu),
    .rob_id_from_alu          (rob_id_from_alu),
    .result_from_alu          (result_from_alu),
    .enable_from_lsu          (enable_from_lsu),
    .rob_id_from_lsu          (rob_id_from_lsu),
    .result_from_lsu          (result_from_lsu),
    .rollback_flag_from_rob   (rollback_flag_from_rob),
    .enable_to_alu            (enable_to_alu),
    .op_enum_to_alu           (op_enum_to_alu),
    .V1_to_alu                (V1_to_alu),
    .V2_to_alu                (V2_to_alu),
    .imm_to_alu               (imm_to_alu),
    .inst_pos_to_alu          (inst_pos_to_alu),
    .rob_id_to_alu            (rob_id_to_alu)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: slot array plus the expected issue register.
  bit               m_busy [RS_SIZE];
  logic [OP_W-1:0]  m_op   [RS_SIZE];
  logic [31:0]      m_v1   [RS_SIZE];
  logic [31:0]      m_v2   [RS_SIZE];
  logic [31:0]      m_imm  [RS_SIZE];
  logic [31:0]      m_pc   [RS_SIZE];
  logic [ROB_W-1:0] m_q1   [RS_SIZE];
  logic [ROB_W-1:0] m_q2   [RS_SIZE];
  logic [ROB_W-1:0] m_rob  [RS_SIZE];
  logic             e_en;
  logic [OP_W-1:0]  e_op;
  logic [31:0]      e_v1, e_v2, e_imm, e_pc;
  logic [ROB_W-1:0] e_rob;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
  endtask

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < int'(RS_SIZE); i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(RS_SIZE); i++) m_busy[i] = 1'b0;
    e_en = 1'b0; e_op = OP_W'(OP_ENUM_RESET);
    e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = RR;
  endtask

  // Resolve one operand against this cycle's broadcasts (ALU first).
  task automatic snoop(input logic [ROB_W-1:0] qi, input logic [31:0] vi,
                       output logic [ROB_W-1:0] qo, output logic [31:0] vo);
    qo = qi; vo = vi;
    if (qi != RR) begin
      if (enable_from_alu && qi == rob_id_from_alu) begin qo = RR; vo = result_from_alu; end
      else if (enable_from_lsu && qi == rob_id_from_lsu) begin qo = RR; vo = result_from_lsu; end
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int iss, fre;
    logic [ROB_W-1:0] q;
    logic [31:0] v;
    if (!rst_in) model_reset();
    else if (rollback_flag_from_rob) begin
      for (int i = 0; i < int'(RS_SIZE); i++) m_busy[i] = 1'b0;
      e_en = 1'b0;
    end else if (!rdy_in) e_en = 1'b0;
    else begin
      assert (!(enable_from_dispatcher && busy_count() == int'(RS_SIZE)))
        else $error("dispatcher inserted into a full station");
      iss = -1; fre = -1;
      for (int i = 0; i < int'(RS_SIZE); i++)
        if (iss < 0 && m_busy[i] && m_q1[i] == RR && m_q2[i] == RR) iss = i;
      for (int i = 0; i < int'(RS_SIZE); i++)
        if (fre < 0 && !m_busy[i]) fre = i;
      e_en = (iss >= 0);
      if (iss >= 0) begin
        e_op = m_op[iss]; e_v1 = m_v1[iss]; e_v2 = m_v2[iss];
        e_imm = m_imm[iss]; e_pc = m_pc[iss]; e_rob = m_rob[iss];
        m_busy[iss] = 1'b0;
      end
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (m_busy[i]) begin
          snoop(m_q1[i], m_v1[i], q, v); m_q1[i] = q; m_v1[i] = v;
          snoop(m_q2[i], m_v2[i], q, v); m_q2[i] = q; m_v2[i] = v;
        end
      end
      if (enable_from_dispatcher && fre >= 0) begin
        m_busy[fre] = 1'b1;
        m_op[fre] = op_enum_from_dispatcher;
        snoop(Q1_from_dispatcher, V1_from_dispatcher, q, v); m_q1[fre] = q; m_v1[fre] = v;
        snoop(Q2_from_dispatcher, V2_from_dispatcher, q, v); m_q2[fre] = q; m_v2[fre] = v;
        m_imm[fre] = imm_from_dispatcher; m_pc[fre] = inst_pos_from_dispatcher;
        m_rob[fre] = rob_id_from_dispatcher;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("enable_to_alu", 32'(enable_to_alu), 32'(e_en));
    check_eq("is_full", 32'(is_full_to_dispatcher), 32'(busy_count() >= int'(RS_SIZE) - 1));
    check_eq("op_enum_to_alu", 32'(op_enum_to_alu), 32'(e_op));
    check_eq("V1_to_alu", V1_to_alu, e_v1);
    check_eq("V2_to_alu", V2_to_alu, e_v2);
    check_eq("imm_to_alu", imm_to_alu, e_imm);
    check_eq("inst_pos_to_alu", inst_pos_to_alu, e_pc);
    check_eq("rob_id_to_alu", 32'(rob_id_to_alu), 32'(e_rob));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rdy_in = 1'b1; rollback_flag_from_rob = 1'b0;
    enable_from_dispatcher = 1'b0; enable_from_alu = 1'b0; enable_from_lsu = 1'b0;
  endtask

  task automatic put(input logic [OP_W-1:0] op, input logic [31:0] v1, input logic [31:0] v2,
                     input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                     input logic [ROB_W-1:0] rob);
    enable_from_dispatcher = 1'b1; op_enum_from_dispatcher = op;
    V1_from_dispatcher = v1; V2_from_dispatcher = v2;
    Q1_from_dispatcher = q1; Q2_from_dispatcher = q2;
    imm_from_dispatcher = $urandom; inst_pos_from_dispatcher = $urandom;
    rob_id_from_dispatcher = rob;
  endtask

  task automatic bcast_alu(input logic [ROB_W-1:0] tag, input logic [31:0] val);
    enable_from_alu = 1'b1; rob_id_from_alu = tag; result_from_alu = val;
  endtask

  task automatic bcast_lsu(input logic [ROB_W-1:0] tag, input logic [31:0] val);
    enable_from_lsu = 1'b1; rob_id_from_lsu = tag; result_from_lsu = val;
  endtask

  initial begin
    rst_in = 1'b1;
    idle();
    op_enum_from_dispatcher = '0; V1_from_dispatcher = '0; V2_from_dispatcher = '0;
    Q1_from_dispatcher = RR; Q2_from_dispatcher = RR; imm_from_dispatcher = '0;
    inst_pos_from_dispatcher = '0; rob_id_from_dispatcher = '0;
    rob_id_from_alu = '0; result_from_alu = '0; rob_id_from_lsu = '0; result_from_lsu = '0;
    #2 rst_in = 1'b0;
    #1;
    model_reset();
    compare_all();
    step(); step();
    rst_in = 1'b1;

    // Basic issue: ready operands issue one edge after insert.
    put(OP_W'(OP_ENUM_ADD), 32'd5, 32'd7, RR, RR, 5'd3); step();
    check_eq("basic_not_early", 32'(enable_to_alu), 32'd0);
    idle(); step();
    check_eq("basic_en", 32'(enable_to_alu), 32'd1);
    check_eq("basic_v1", V1_to_alu, 32'd5);
    check_eq("basic_v2", V2_to_alu, 32'd7);
    check_eq("basic_rob", 32'(rob_id_to_alu), 32'd3);
    step();
    check_eq("basic_pulse", 32'(enable_to_alu), 32'd0);

    // Wake from ALU two cycles after insert.
    put(OP_W'(OP_ENUM_SUB), 32'd0, 32'd11, 5'd4, RR, 5'd7); step();
    idle(); step();
    bcast_alu(5'd4, 32'h1234); step();
    check_eq("wake_not_early", 32'(enable_to_alu), 32'd0);
    idle(); step();
    check_eq("wake_en", 32'(enable_to_alu), 32'd1);
    check_eq("wake_v1", V1_to_alu, 32'h1234);

    // Same-cycle snoop, LSU alone then ALU and LSU together.
    put(OP_W'(OP_ENUM_OR), 32'd1, 32'd0, RR, 5'd9, 5'd8); bcast_lsu(5'd9, 32'hDEAD); step();
    idle(); step();
    check_eq("snoop_lsu_en", 32'(enable_to_alu), 32'd1);
    check_eq("snoop_lsu_v2", V2_to_alu, 32'hDEAD);
    put(OP_W'(OP_ENUM_OR), 32'd1, 32'd0, RR, 5'd9, 5'd8);
    bcast_alu(5'd9, 32'hAAAA); bcast_lsu(5'd9, 32'hDEAD); step();
    idle(); step();
    check_eq("snoop_both_v2", V2_to_alu, 32'hAAAA);
    step();

    // Fill to full, then drain in index order.
    for (int k = 0; k < 15; k++) begin
      put(OP_W'(OP_ENUM_ADD), 32'(k), 32'(k), 5'd2, RR, ROB_W'(16 + k)); step();
      if (k == 13) check_eq("full_at_14", 32'(is_full_to_dispatcher), 32'd0);
      if (k == 14) check_eq("full_at_15", 32'(is_full_to_dispatcher), 32'd1);
    end
    put(OP_W'(OP_ENUM_ADD), 32'd15, 32'd15, 5'd2, RR, 5'd31); step();
    check_eq("full_at_16", 32'(is_full_to_dispatcher), 32'd1);
    idle(); bcast_alu(5'd2, 32'h5555); step();
    idle();
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq("drain_en", 32'(enable_to_alu), 32'd1);
      check_eq("drain_rob", 32'(rob_id_to_alu), 32'(16 + k));
      check_eq("drain_v1", V1_to_alu, 32'h5555);
    end
    step();
    check_eq("drain_done", 32'(enable_to_alu), 32'd0);

    // Rollback discards entries, the concurrent insert and the broadcast.
    for (int k = 0; k < 6; k++) begin
      put(OP_W'(OP_ENUM_XOR), 32'd1, 32'd2, 5'd5, RR, ROB_W'(10 + k)); step();
    end
    put(OP_W'(OP_ENUM_ADD), 32'd1, 32'd1, RR, RR, 5'd20); bcast_alu(5'd5, 32'h77);
    rollback_flag_from_rob = 1'b1; step();
    check_eq("rollback_en", 32'(enable_to_alu), 32'd0);
    check_eq("rollback_full", 32'(is_full_to_dispatcher), 32'd0);
    idle(); bcast_alu(5'd5, 32'h77); step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rollback_no_issue", 32'(enable_to_alu), 32'd0);
    end

    // rdy_in low freezes ready entries and ignores inserts.
    for (int k = 1; k <= 3; k++) begin
      put(OP_W'(OP_ENUM_AND), 32'(k), 32'd0, 5'd6, RR, ROB_W'(k)); step();
    end
    idle(); bcast_alu(5'd6, 32'h66); step();
    idle(); rdy_in = 1'b0; put(OP_W'(OP_ENUM_ADD), 32'd0, 32'd0, RR, RR, 5'd25);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rdy_low_no_issue", 32'(enable_to_alu), 32'd0);
    end
    idle();
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("rdy_resume_rob", 32'(rob_id_to_alu), 32'(k));
    end
    step();
    check_eq("rdy_insert_dropped", 32'(enable_to_alu), 32'd0);

    // Asynchronous reset in the middle of a burst of issues.
    for (int k = 0; k < 3; k++) begin
      put(OP_W'(OP_ENUM_ADDI), 32'h99, 32'h98, RR, RR, ROB_W'(k + 4)); step();
    end
    idle();
    rst_in = 1'b0;
    #1;
    check_eq("async_rst_en", 32'(enable_to_alu), 32'd0);
    check_eq("async_rst_op", 32'(op_enum_to_alu), 32'(OP_ENUM_RESET));
    check_eq("async_rst_v1", V1_to_alu, 32'd0);
    check_eq("async_rst_rob", 32'(rob_id_to_alu), 32'(RR));
    check_eq("async_rst_full", 32'(is_full_to_dispatcher), 32'd0);
    model_reset();
    step(); step();
    rst_in = 1'b1;
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      rollback_flag_from_rob = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0 && busy_count() < int'(RS_SIZE) - 1)
        put(OP_W'($urandom_range(0, 63)), $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? RR : ROB_W'($urandom_range(1, 7)),
            ($urandom_range(0, 2) == 0) ? RR : ROB_W'($urandom_range(1, 7)),
            ROB_W'($urandom_range(1, 31)));
      if ($urandom_range(0, 1) == 1) bcast_alu(ROB_W'($urandom_range(1, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) bcast_lsu(ROB_W'($urandom_range(1, 7)), $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
